pipe_stage_reg: RTL and testbench

Parametrised pipeline-boundary register for the MIPS pipeline, the general successor to the fixed per-boundary control/data register pairs. It carries a control bundle, a data bundle and a valid bit through DEPTH register stages, with stall (hold), flush (bubble insertion) and a saturating bubble counter for performance monitoring. It is instantiated once per boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with widths set per boundary.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_stage.sv | 37 +++
 rtl/pipe_stage_reg.sv | 86 ++++++++
 tb/tb_pipe_stage_reg.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, ID/EX control field offsets and helpers for the pipeline boundary registers.
// Pure declarations: no logic, no latency, no flow control.
package pipe_pkg;

    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 11;
    localparam int IDEX_DATA_W  = 143;
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 101;
    localparam int MEMWB_CTRL_W = 3;
    localparam int MEMWB_DATA_W = 101;

    // ID/EX control bundle layout, LSB offsets (msb to lsb: alu_op .. mem_to_reg)
    localparam int IDEX_ALU_OP_LSB     = 8;
    localparam int IDEX_ALU_SRC_LSB    = 7;
    localparam int IDEX_REG_WRITE_LSB  = 6;
    localparam int IDEX_REG_DST_LSB    = 4;
    localparam int IDEX_MEM_READ_LSB   = 3;
    localparam int IDEX_MEM_WRITE_LSB  = 2;
    localparam int IDEX_MEM_TO_REG_LSB = 0;

    localparam logic [IDEX_CTRL_W-1:0] CTRL_BUBBLE = '0;

    function automatic logic [IDEX_CTRL_W-1:0] idex_ctrl_pack(
        input logic [2:0] alu_op,
        input logic       alu_src,
        input logic       reg_write,
        input logic [1:0] reg_dst,
        input logic       mem_read,
        input logic       mem_write,
        input logic [1:0] mem_to_reg
    );
        return {alu_op, alu_src, reg_write, reg_dst, mem_read, mem_write, mem_to_reg};
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One {valid, ctrl, data} register with kill > load > hold priority.
// Latency: one edge from load to output. Backpressure: load=0 holds contents.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              kill,
    input  logic              v_in,
    input  logic [CTRL_W-1:0] c_in,
    input  logic [DATA_W-1:0] d_in,
    output logic              v,
    output logic [CTRL_W-1:0] c,
    output logic [DATA_W-1:0] d
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v <= 1'b0;
            c <= '0;
            d <= '0;
        end else if (kill) begin
            // data is left in place; only the valid/control side is squashed
            v <= 1'b0;
            c <= '0;
        end else if (load) begin
            v <= v_in;
            c <= v_in ? c_in : '0;
            d <= d_in;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: DEPTH stages of {valid, ctrl, data} plus a saturating bubble counter.
// Latency: DEPTH edges from input to output, plus one per stalled edge.
// Backpressure: stall holds all stages; flush squashes them and drops the entry at the inputs.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cnt_clr,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              adv;
    logic              bump;
    logic [DEPTH-1:0]  v_s;
    logic [CTRL_W-1:0] c_s [DEPTH];
    logic [DATA_W-1:0] d_s [DEPTH];

    assign adv  = !flush && !stall;
    assign bump = flush || (adv && !valid_in);

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            logic              v_src;
            logic [CTRL_W-1:0] c_src;
            logic [DATA_W-1:0] d_src;

            if (k == 0) begin : g_head
                assign v_src = valid_in;
                assign c_src = ctrl_in;
                assign d_src = data_in;
            end else begin : g_tail
                assign v_src = v_s[k-1];
                assign c_src = c_s[k-1];
                assign d_src = d_s[k-1];
            end

            pipe_stage #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .load (adv),
                .kill (flush),
                .v_in (v_src),
                .c_in (c_src),
                .d_in (d_src),
                .v    (v_s[k]),
                .c    (c_s[k]),
                .d    (d_s[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (bump && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign valid_out = v_s[DEPTH-1];
    assign ctrl_out  = c_s[DEPTH-1];
    assign data_out  = d_s[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Three instances (DEPTH 1/3/4, the last with a 4-bit counter) driven in lockstep and
// compared against a queue-style model, hand-computed vectors and corner-case sequences.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall, flush, valid_in, cnt_clr;
    logic [10:0]  ctrl_in;
    logic [142:0] data_in;

    logic [2:0]         ov;
    logic [2:0][10:0]   oc;
    logic [2:0][142:0]  od;
    logic [2:0][15:0]   ocnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         v;
        logic [10:0]  c;
        logic [142:0] d;
    } ent_t;

    ent_t mdl [3][4];
    int   dep  [3] = '{1, 3, 4};
    int   cmax [3] = '{65535, 65535, 15};
    int   cnt  [3];

    typedef struct {
        logic         s, f, vi;
        logic [10:0]  ci;
        logic [142:0] di;
        logic         clr;
        logic         ev;
        logic [10:0]  ec;
        logic [142:0] ed;
        int           ecnt;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(11), .DATA_W(143), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr),
        .valid_out(ov[0]), .ctrl_out(oc[0]), .data_out(od[0]), .bubble_cnt(ocnt[0]));

    pipe_stage_reg #(.CTRL_W(11), .DATA_W(143), .DEPTH(3), .CNT_W(16)) u_d3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr),
        .valid_out(ov[1]), .ctrl_out(oc[1]), .data_out(od[1]), .bubble_cnt(ocnt[1]));

    pipe_stage_reg #(.CTRL_W(11), .DATA_W(143), .DEPTH(4), .CNT_W(4)) u_d4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr),
        .valid_out(ov[2]), .ctrl_out(oc[2]), .data_out(od[2]), .bubble_cnt(ocnt[2][3:0]));

    assign ocnt[2][15:4] = '0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            for (int k = 0; k < 4; k++) mdl[i][k] = '{1'b0, 11'h0, 143'h0};
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            ent_t e;
            e = mdl[i][dep[i]-1];
            chk($sformatf("%s.d%0d.valid", tag, dep[i]), ov[i], e.v);
            chk($sformatf("%s.d%0d.ctrl", tag, dep[i]), oc[i], e.c);
            chk($sformatf("%s.d%0d.data", tag, dep[i]), od[i], e.d);
            chk($sformatf("%s.d%0d.cnt", tag, dep[i]), ocnt[i], cnt[i]);
        end
    endtask

    // Apply one edge's worth of inputs, update the model, then compare all instances.
    task automatic step(input string tag, input logic s, input logic f, input logic vi,
                        input logic [10:0] ci, input logic [142:0] di, input logic clr);
        stall = s; flush = f; valid_in = vi; ctrl_in = ci; data_in = di; cnt_clr = clr;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (clr) cnt[i] = 0;
            else if (f || (!s && !vi)) cnt[i] = (cnt[i] < cmax[i]) ? cnt[i] + 1 : cmax[i];
            if (f) begin
                for (int k = 0; k < 4; k++) begin
                    mdl[i][k].v = 1'b0;
                    mdl[i][k].c = 11'h0;
                end
            end else if (!s) begin
                for (int k = 3; k > 0; k--) mdl[i][k] = mdl[i][k-1];
                mdl[i][0] = '{vi, vi ? ci : 11'h0, di};
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic chk_out(input string nm, input int i, input logic ev,
                           input logic [10:0] ec, input logic [142:0] ed);
        chk({nm, ".valid"}, ov[i], ev);
        chk({nm, ".ctrl"}, oc[i], ec);
        chk({nm, ".data"}, od[i], ed);
    endtask

    initial begin
        logic [159:0] rnd;
        int           cbefore;

        tbl[0] = '{0, 0, 1, 11'h5A3, 143'h1234, 0, 1, 11'h5A3, 143'h1234, 0};
        tbl[1] = '{0, 0, 0, 11'h7FF, 143'h55,   0, 0, 11'h000, 143'h55,   1};
        tbl[2] = '{1, 0, 1, 11'h123, 143'h99,   0, 0, 11'h000, 143'h55,   1};
        tbl[3] = '{1, 1, 1, 11'h7FF, 143'h77,   0, 0, 11'h000, 143'h55,   2};
        tbl[4] = '{0, 0, 1, 11'h7FF, 143'hAB,   0, 1, 11'h7FF, 143'hAB,   2};
        tbl[5] = '{0, 1, 1, 11'h001, 143'hCD,   0, 0, 11'h000, 143'hAB,   3};
        tbl[6] = '{0, 0, 0, 11'h003, 143'hEF,   1, 0, 11'h000, 143'hEF,   0};
        tbl[7] = '{0, 0, 1, 11'h2AA, 143'h1,    0, 1, 11'h2AA, 143'h1,    0};

        rst = 1'b0; stall = 0; flush = 0; valid_in = 0; cnt_clr = 0;
        ctrl_in = '0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // Hand-computed vectors for the DEPTH=1 instance, model checks for all.
        for (int n = 0; n < 8; n++) begin
            step($sformatf("tbl%0d", n), tbl[n].s, tbl[n].f, tbl[n].vi, tbl[n].ci,
                 tbl[n].di, tbl[n].clr);
            chk_out($sformatf("tbl%0d.hand", n), 0, tbl[n].ev, tbl[n].ec, tbl[n].ed);
            chk($sformatf("tbl%0d.hand.cnt", n), ocnt[0], tbl[n].ecnt);
        end

        // Asynchronous reset mid-stall with live contents: outputs clear before any edge.
        stall = 1'b1; valid_in = 1'b1; ctrl_in = 11'h7FF;
        #3 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("async_rst.i%0d", i), i, 1'b0, 11'h0, 143'h0);
            chk($sformatf("async_rst.i%0d.cnt", i), ocnt[i], 0);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;

        // Stall on DEPTH=3: A,B,C then two stalled edges.
        step("stA", 0, 0, 1, 11'h0A1, 143'hA, 0);
        step("stB", 0, 0, 1, 11'h0B2, 143'hB, 0);
        step("stC", 0, 0, 1, 11'h0C3, 143'hC, 0);
        chk_out("stall.A0", 1, 1'b1, 11'h0A1, 143'hA);
        step("st1", 1, 0, 1, 11'h0D4, 143'hD, 0);
        chk_out("stall.A1", 1, 1'b1, 11'h0A1, 143'hA);
        step("st2", 1, 0, 1, 11'h0D4, 143'hD, 0);
        chk_out("stall.A2", 1, 1'b1, 11'h0A1, 143'hA);
        step("stD", 0, 0, 0, 11'h0, 143'h0, 0);
        chk_out("stall.B", 1, 1'b1, 11'h0B2, 143'hB);
        step("stE", 0, 0, 0, 11'h0, 143'h0, 0);
        chk_out("stall.C", 1, 1'b1, 11'h0C3, 143'hC);
        step("stF", 0, 0, 0, 11'h0, 143'h0, 0);
        chk("stall.bubble.valid", ov[1], 1'b0);

        // Flush together with stall after loading all-ones control.
        step("flX", 0, 0, 1, 11'h7FF, 143'h111, 0);
        step("flY", 0, 0, 1, 11'h7FF, 143'h222, 0);
        step("flZ", 0, 0, 1, 11'h7FF, 143'h333, 0);
        chk_out("flush.pre", 1, 1'b1, 11'h7FF, 143'h111);
        cbefore = cnt[1];
        step("flush", 1, 1, 1, 11'h7FF, 143'h444, 0);
        chk_out("flush.d3", 1, 1'b0, 11'h0, 143'h111);
        chk_out("flush.d1", 0, 1'b0, 11'h0, 143'h333);
        chk("flush.cnt_inc", ocnt[1], cbefore + 1);

        // Saturation of the 4-bit counter, then clear beating a same-edge bubble.
        for (int n = 0; n < 20; n++) step("sat", 0, 0, 0, 11'h7FF, 143'h5, 0);
        chk("sat.cnt4", ocnt[2], 15);
        step("clr", 0, 0, 0, 11'h7FF, 143'h6, 1);
        chk("clr.cnt4", ocnt[2], 0);
        chk("clr.cnt1", ocnt[0], 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7), 11'($urandom()), rnd[142:0],
                 ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
